vector_activation_unit: RTL and testbench



---
 rtl/vector_activation_unit_pkg.sv | 20 ++
 rtl/vector_activation_unit_lane.sv | 41 ++++
 rtl/vector_activation_unit.sv | 158 +++++++++++++++
 tb/tb_vector_activation_unit.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_activation_unit_pkg.sv
// Shared types for the vector activation unit: activation modes, FSM states
// and the lane width.
package act_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    PASS      = 2'd0,
    RELU      = 2'd1,
    RELU_CLIP = 2'd2,
    LEAKY     = 2'd3
  } act_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } act_state_e;

endpackage

// File: rtl/vector_activation_unit_lane.sv
// Single-element activation, purely combinational.
//   x          signed input element
//   mode       activation mode
//   clip_max   RELU_CLIP upper bound (unsigned, saturated to 127)
//   leak_shift LEAKY arithmetic right-shift amount for negative inputs
//   y          activated element
module act_lane
  import act_pkg::*;
(
  input  logic signed [LANE_W-1:0] x,
  input  act_mode_e                mode,
  input  logic        [7:0]        clip_max,
  input  logic        [2:0]        leak_shift,
  output logic signed [LANE_W-1:0] y
);

  logic signed [LANE_W-1:0] lim;

  always_comb begin
    lim = clip_max[7] ? 8'sd127 : $signed({1'b0, clip_max[6:0]});
    y   = x;
    case (mode)
      PASS: y = x;
      RELU: y = x[LANE_W-1] ? '0 : x;
      RELU_CLIP: begin
        if (x[LANE_W-1])
          y = '0;
        else if (x > lim)
          y = lim;
        else
          y = x;
      end
      LEAKY: begin
        if (x[LANE_W-1])
          y = x >>> leak_shift;
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/vector_activation_unit.sv
// Streaming activation stage: fetches a vector chunk-by-chunk from a
// single-cycle-latency buffer, activates each lane and writes chunks to a
// downstream buffer that may apply backpressure.
//   clk_in/rst_n_in            clock, async active-low reset
//   in_data_ready              start request (sampled in IDLE)
//   mode_in/clip_max_in/...    config, latched at accept
//   in_data/read_in_req_ptr    upstream buffer read port
//   write_out_*                downstream buffer write port
//   out_ready                  downstream accept
//   out_vector_valid           marks the final chunk's write
//   busy                       not IDLE
module vector_activation_unit
  import act_pkg::*;
#(
  parameter  int InVecLength = 16,
  parameter  int WorkingRegs = 4,
  localparam int PtrW        = (InVecLength > 1) ? $clog2(InVecLength) : 1
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic                                in_data_ready,
  input  logic [1:0]                          mode_in,
  input  logic [7:0]                          clip_max_in,
  input  logic [2:0]                          leak_shift_in,
  input  logic [WorkingRegs-1:0][LANE_W-1:0]  in_data,
  output logic [PtrW-1:0]                     read_in_req_ptr,
  output logic [PtrW-1:0]                     write_out_req_ptr,
  output logic [WorkingRegs-1:0][LANE_W-1:0]  write_out_data,
  output logic                                write_out_en,
  input  logic                                out_ready,
  output logic                                out_vector_valid,
  output logic                                busy
);

  localparam int              NumChunks = InVecLength / WorkingRegs;
  localparam logic [PtrW-1:0] STEP      = PtrW'(WorkingRegs);
  localparam logic [PtrW-1:0] LAST      = PtrW'(InVecLength - WorkingRegs);

  act_state_e state, state_nxt;

  act_mode_e  cfg_mode;
  logic [7:0] cfg_clip;
  logic [2:0] cfg_shift;

  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] wr_ptr;
  logic            wr_en;
  logic            hold_valid;
  logic [WorkingRegs-1:0][LANE_W-1:0] hold_data;
  logic [WorkingRegs-1:0][LANE_W-1:0] src_data;
  logic [WorkingRegs-1:0][LANE_W-1:0] act_data;

  logic stall;
  logic wr_acc;

  assign stall  = wr_en & ~out_ready;
  assign wr_acc = wr_en & out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_data_ready) begin
          if (NumChunks == 1)
            state_nxt = FLUSH;
          else
            state_nxt = RUN;
        end
      end
      RUN: begin
        if (wr_acc && rd_ptr == LAST)
          state_nxt = FLUSH;
      end
      FLUSH: begin
        if (wr_acc)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // The write port shows buffer data combinationally; the read pointer runs
  // one chunk ahead, so a stall parks the in-flight chunk in hold_data.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cfg_mode   <= PASS;
      cfg_clip   <= '0;
      cfg_shift  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      wr_en      <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      if (stall && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_data  <= in_data;
      end
      if (wr_acc)
        hold_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (in_data_ready) begin
            cfg_mode  <= act_mode_e'(mode_in);
            cfg_clip  <= clip_max_in;
            cfg_shift <= leak_shift_in;
            wr_en     <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= (NumChunks == 1) ? '0 : STEP;
          end
        end
        RUN: begin
          if (wr_acc) begin
            wr_ptr <= wr_ptr + STEP;
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + STEP;
          end
        end
        FLUSH: begin
          if (wr_acc) begin
            wr_en  <= 1'b0;
            wr_ptr <= '0;
          end
        end
        default: begin
          wr_en <= 1'b0;
        end
      endcase
    end
  end

  assign src_data = hold_valid ? hold_data : in_data;

  for (genvar g = 0; g < WorkingRegs; g++) begin : g_lane
    act_lane u_lane (
      .x          (src_data[g]),
      .mode       (cfg_mode),
      .clip_max   (cfg_clip),
      .leak_shift (cfg_shift),
      .y          (act_data[g])
    );
  end

  assign write_out_data    = wr_en ? act_data : '0;
  assign write_out_en      = wr_en;
  assign write_out_req_ptr = wr_ptr;
  assign read_in_req_ptr   = rd_ptr;
  assign out_vector_valid  = wr_en && (wr_ptr == LAST);
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_vector_activation_unit.sv
module tb_vector_activation_unit;
  import act_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_data_ready;
  logic [1:0]       mode_in;
  logic [7:0]       clip_max_in;
  logic [2:0]       leak_shift_in;
  logic             out_ready;
  logic [3:0][7:0]  in_data;
  logic [3:0][7:0]  wod;
  logic [3:0]       rptr;
  logic [3:0]       wptr;
  logic             wen;
  logic             vvalid;
  logic             busy;

  logic             in_data_ready_s;
  logic             out_ready_s;
  logic [3:0][7:0]  in_data_s;
  logic [3:0][7:0]  wod_s;
  logic [1:0]       rptr_s;
  logic [1:0]       wptr_s;
  logic             wen_s;
  logic             vvalid_s;
  logic             busy_s;

  logic signed [7:0] mem   [16];
  logic signed [7:0] mem_s [4];
  logic [3:0]        ptr_q;
  logic [1:0]        ptr_q_s;
  int                acc_cnt = 0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  vector_activation_unit #(.InVecLength(16), .WorkingRegs(4)) u_dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .in_data_ready     (in_data_ready),
    .mode_in           (mode_in),
    .clip_max_in       (clip_max_in),
    .leak_shift_in     (leak_shift_in),
    .in_data           (in_data),
    .read_in_req_ptr   (rptr),
    .write_out_req_ptr (wptr),
    .write_out_data    (wod),
    .write_out_en      (wen),
    .out_ready         (out_ready),
    .out_vector_valid  (vvalid),
    .busy              (busy)
  );

  vector_activation_unit #(.InVecLength(4), .WorkingRegs(4)) u_small (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .in_data_ready     (in_data_ready_s),
    .mode_in           (mode_in),
    .clip_max_in       (clip_max_in),
    .leak_shift_in     (leak_shift_in),
    .in_data           (in_data_s),
    .read_in_req_ptr   (rptr_s),
    .write_out_req_ptr (wptr_s),
    .write_out_data    (wod_s),
    .write_out_en      (wen_s),
    .out_ready         (out_ready_s),
    .out_vector_valid  (vvalid_s),
    .busy              (busy_s)
  );

  // Upstream buffers with single-cycle read latency.
  always @(posedge clk) begin
    ptr_q   <= rptr;
    ptr_q_s <= rptr_s;
    if (wen && out_ready)
      acc_cnt <= acc_cnt + 1;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      in_data[i]   = mem[ptr_q + 4'(i)];
      in_data_s[i] = mem_s[ptr_q_s + 2'(i)];
    end
  end

  function automatic logic [3:0][7:0] p4(input int a, input int b, input int c, input int d);
    logic [3:0][7:0] r;
    r[0] = 8'(a);
    r[1] = 8'(b);
    r[2] = 8'(c);
    r[3] = 8'(d);
    return r;
  endfunction

  task automatic load_a();
    int v[16] = '{-3, 5, -128, 127, 0, -1, 2, -2, 10, -10, 64, -64, 1, -7, 100, -100};
    for (int i = 0; i < 16; i++) mem[i] = 8'(v[i]);
  endtask

  task automatic start_vec(input logic [1:0] m, input logic [7:0] cm, input logic [2:0] sh);
    @(posedge clk); #1;
    in_data_ready = 1'b1;
    mode_in       = m;
    clip_max_in   = cm;
    leak_shift_in = sh;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({wen, vvalid, busy, rptr, wptr, wod} !== '0) $display("FAIL reset_main: got %h expected 0", {wen, vvalid, busy, rptr, wptr, wod});
    else pass_cnt++;
    total_cnt++;
    if ({wen_s, vvalid_s, busy_s, rptr_s, wptr_s, wod_s} !== '0) $display("FAIL reset_small: got %h expected 0", {wen_s, vvalid_s, busy_s, rptr_s, wptr_s, wod_s});
    else pass_cnt++;
  endtask

  task automatic test_relu_stream();
    logic [3:0][7:0] e [4];
    e[0] = p4(0, 5, 0, 127);
    e[1] = p4(0, 0, 2, 0);
    e[2] = p4(10, 0, 64, 0);
    e[3] = p4(1, 0, 100, 0);
    load_a();
    out_ready = 1'b1;
    start_vec(2'd1, 8'd0, 3'd0);
    for (int c = 1; c <= 4; c++) begin
      int k = c - 1;
      @(posedge clk); #1;
      in_data_ready = (c == 2);
      if (c == 2) begin
        mode_in       = 2'd0;
        clip_max_in   = 8'd1;
        leak_shift_in = 3'd7;
      end
      @(negedge clk);
      total_cnt++;
      if (wen !== 1'b1 || wptr !== 4'(4 * k)) $display("FAIL relu_wr c%0d: got en=%b ptr=%0d expected en=1 ptr=%0d", c, wen, wptr, 4 * k);
      else pass_cnt++;
      total_cnt++;
      if (rptr !== ((k == 3) ? 4'd0 : 4'(4 * (k + 1)))) $display("FAIL relu_rptr c%0d: got %0d", c, rptr);
      else pass_cnt++;
      total_cnt++;
      if (wod !== e[k]) $display("FAIL relu_data c%0d: got %h expected %h", c, wod, e[k]);
      else pass_cnt++;
      total_cnt++;
      if (vvalid !== (k == 3)) $display("FAIL relu_vvalid c%0d: got %b expected %b", c, vvalid, (k == 3));
      else pass_cnt++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if (wen !== 1'b0 || busy !== 1'b0) $display("FAIL relu_end: got en=%b busy=%b expected 0 0", wen, busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL relu_no_restart: got busy=%b expected 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_relu_clip();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = -8'sd5; mem[1] = 8'sd3; mem[2] = 8'sd6; mem[3] = 8'sd100;
    start_vec(2'd2, 8'd6, 3'd0);
    @(posedge clk); #1; in_data_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (wod !== p4(0, 3, 6, 6)) $display("FAIL clip6: got %h expected %h", wod, p4(0, 3, 6, 6));
    else pass_cnt++;
    begin
      int n = 0;
      while (busy && n < 20) begin @(negedge clk); n++; end
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL clip6_drain: got busy=%b expected 0", busy);
      else pass_cnt++;
    end
    mem[0] = 8'sd100; mem[1] = 8'sd127; mem[2] = -8'sd1; mem[3] = 8'sd50;
    start_vec(2'd2, 8'd200, 3'd0);
    @(posedge clk); #1; in_data_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (wod !== p4(100, 127, 0, 50)) $display("FAIL clip200: got %h expected %h", wod, p4(100, 127, 0, 50));
    else pass_cnt++;
    begin
      int n = 0;
      while (busy && n < 20) begin @(negedge clk); n++; end
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL clip200_drain: got busy=%b expected 0", busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_leaky();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = -8'sd8;  mem[1] = -8'sd1; mem[2] = -8'sd128; mem[3] = 8'sd7;
    mem[4] = -8'sd16; mem[5] = -8'sd3; mem[6] = 8'sd5;    mem[7] = -8'sd2;
    start_vec(2'd3, 8'd0, 3'd2);
    @(posedge clk); #1; in_data_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (wod !== p4(-2, -1, -32, 7)) $display("FAIL leaky_c0: got %h expected %h", wod, p4(-2, -1, -32, 7));
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (wod !== p4(-4, -1, 5, -1)) $display("FAIL leaky_c1: got %h expected %h", wod, p4(-4, -1, 5, -1));
    else pass_cnt++;
    begin
      int n = 0;
      while (busy && n < 20) begin @(negedge clk); n++; end
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL leaky_drain: got busy=%b expected 0", busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [3:0][7:0] e [4];
    int ptr_e [9]  = '{0, 4, 4, 4, 4, 8, 12, 12, 12};
    int chk_e [9]  = '{0, 1, 1, 1, 1, 2, 3, 3, 3};
    int rptr_e [9] = '{4, 8, 8, 8, 8, 12, 0, 0, 0};
    int acc0;
    e[0] = p4(0, 5, 0, 127);
    e[1] = p4(0, 0, 2, 0);
    e[2] = p4(10, 0, 64, 0);
    e[3] = p4(1, 0, 100, 0);
    load_a();
    acc0 = acc_cnt;
    start_vec(2'd1, 8'd0, 3'd0);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      in_data_ready = 1'b0;
      out_ready = !((c >= 2 && c <= 4) || (c >= 7 && c <= 8));
      @(negedge clk);
      total_cnt++;
      if (wen !== 1'b1 || wptr !== 4'(ptr_e[c-1]) || rptr !== 4'(rptr_e[c-1]))
        $display("FAIL bp_ptr c%0d: got en=%b wptr=%0d rptr=%0d expected en=1 wptr=%0d rptr=%0d", c, wen, wptr, rptr, ptr_e[c-1], rptr_e[c-1]);
      else pass_cnt++;
      total_cnt++;
      if (wod !== e[chk_e[c-1]]) $display("FAIL bp_data c%0d: got %h expected %h", c, wod, e[chk_e[c-1]]);
      else pass_cnt++;
      total_cnt++;
      if (vvalid !== (c >= 7)) $display("FAIL bp_vvalid c%0d: got %b expected %b", c, vvalid, (c >= 7));
      else pass_cnt++;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || wen !== 1'b0) $display("FAIL bp_end: got busy=%b en=%b expected 0 0", busy, wen);
    else pass_cnt++;
    total_cnt++;
    if (acc_cnt - acc0 !== 4) $display("FAIL bp_write_count: got %0d expected 4", acc_cnt - acc0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    load_a();
    out_ready = 1'b1;
    start_vec(2'd1, 8'd0, 3'd0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1; in_data_ready = 1'b0;
      @(negedge clk);
    end
    total_cnt++;
    if (wptr !== 4'd8 || wod !== p4(10, 0, 64, 0)) $display("FAIL rst_pre: got ptr=%0d data=%h expected 8 %h", wptr, wod, p4(10, 0, 64, 0));
    else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({wen, vvalid, busy, rptr, wptr, wod} !== '0) $display("FAIL rst_async: got %h expected 0", {wen, vvalid, busy, rptr, wptr, wod});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    start_vec(2'd1, 8'd0, 3'd0);
    @(posedge clk); #1; in_data_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (wen !== 1'b1 || wptr !== 4'd0 || rptr !== 4'd4 || wod !== p4(0, 5, 0, 127))
      $display("FAIL rst_restart: got en=%b wptr=%0d rptr=%0d data=%h expected 1 0 4 %h", wen, wptr, rptr, wod, p4(0, 5, 0, 127));
    else pass_cnt++;
    begin
      int n = 0;
      while (busy && n < 20) begin @(negedge clk); n++; end
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL rst_drain: got busy=%b expected 0", busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_single_chunk();
    mem_s[0] = -8'sd3; mem_s[1] = 8'sd5; mem_s[2] = -8'sd128; mem_s[3] = 8'sd127;
    @(posedge clk); #1;
    in_data_ready_s = 1'b1;
    mode_in         = 2'd1;
    @(posedge clk); #1;
    in_data_ready_s = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (wen_s !== 1'b1 || wptr_s !== 2'd0 || vvalid_s !== 1'b1 || rptr_s !== 2'd0)
      $display("FAIL single_ctl: got en=%b wptr=%0d vvalid=%b rptr=%0d expected 1 0 1 0", wen_s, wptr_s, vvalid_s, rptr_s);
    else pass_cnt++;
    total_cnt++;
    if (wod_s !== p4(0, 5, 0, 127)) $display("FAIL single_data: got %h expected %h", wod_s, p4(0, 5, 0, 127));
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (wen_s !== 1'b0 || busy_s !== 1'b0 || vvalid_s !== 1'b0) $display("FAIL single_end: got en=%b busy=%b vvalid=%b expected 0 0 0", wen_s, busy_s, vvalid_s);
    else pass_cnt++;
  endtask

  initial begin
    rst_n           = 1'b0;
    in_data_ready   = 1'b0;
    in_data_ready_s = 1'b0;
    mode_in         = 2'd0;
    clip_max_in     = 8'd0;
    leak_shift_in   = 3'd0;
    out_ready       = 1'b1;
    out_ready_s     = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem_s[i] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_relu_stream();
    test_relu_clip();
    test_leaky();
    test_backpressure();
    test_reset_mid();
    test_single_chunk();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
